// File: rtl/dmem_pkg.sv
// Shared types for the wait-state data memory: access sizes, FSM states and
// the decode helpers used by both the top and the lane formatter.
package dmem_pkg;

    localparam int unsigned MAX_WAIT_CYCLES = 15;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } dmem_state_e;

    // The unused size code 2'b11 behaves as a full word.
    function automatic mem_size_e decode_size(input logic [1:0] raw);
        case (raw)
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input mem_size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_H:    return lo[0];
            SZ_W:    return |lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ws_if.sv
// Request/response bus between the MEM stage (master) and dmem_ws (slave).
interface dmem_ws_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_lane_fmt.sv
// Combinational RV32I lane handling: store byte enables / replicated data and
// load byte/half extraction with sign or zero extension.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  mem_size_e   size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_al,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = rword[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = byte_lane[addr_lo];
    assign sel_half = addr_lo[1] ? rword[31:16] : rword[15:0];

    // Store data is replicated across lanes so only the enables pick the target.
    always_comb begin
        be        = 4'b1111;
        wdata_al  = wdata;
        load_data = rword;
        case (size)
            SZ_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_al  = {4{wdata[7:0]}};
                load_data = {{24{~is_unsigned & sel_byte[7]}}, sel_byte};
            end
            SZ_H: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_al  = {2{wdata[15:0]}};
                load_data = {{16{~is_unsigned & sel_half[15]}}, sel_half};
            end
            default: begin
                be        = 4'b1111;
                wdata_al  = wdata;
                load_data = rword;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ws.sv
// Data memory with valid/ready request handshake and WAIT_CYCLES wait states.
// Define DMEM_MISALIGN_TRAP_EN to flag and suppress misaligned half/word accesses.
module dmem_ws
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic      clk,
    input  logic      reset,
    dmem_ws_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    dmem_state_e state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;

    logic        we_reg;
    mem_size_e   size_reg;
    logic        uns_reg;
    logic [AW+1:0] addr_reg;
    logic [31:0] wdata_reg;

    logic [31:0] rdata_reg;
    logic        err_reg;

    logic [31:0] mem [DEPTH_WORDS];

    logic        acc_we;
    mem_size_e   acc_size;
    logic        acc_uns;
    logic [AW+1:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [AW-1:0] acc_idx;
    logic        enter_resp;
    logic        trap;
    logic [3:0]  be;
    logic [31:0] wdata_al;
    logic [31:0] load_data;
    logic [31:0] unused_addr;

    assign unused_addr = bus.req_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    cnt_next   = WAIT_INIT;
                    state_next = (WAIT_CYCLES == 0) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) state_next = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state_reg == IDLE && bus.req_valid) begin
            we_reg    <= bus.req_we;
            size_reg  <= decode_size(bus.req_size);
            uns_reg   <= bus.req_unsigned;
            addr_reg  <= bus.req_addr[AW+1:0];
            wdata_reg <= bus.req_wdata;
        end
    end

    // With zero wait states the access happens on the accept edge itself,
    // before the capture registers hold the request.
    always_comb begin
        if (state_reg == IDLE) begin
            acc_we    = bus.req_we;
            acc_size  = decode_size(bus.req_size);
            acc_uns   = bus.req_unsigned;
            acc_addr  = bus.req_addr[AW+1:0];
            acc_wdata = bus.req_wdata;
        end else begin
            acc_we    = we_reg;
            acc_size  = size_reg;
            acc_uns   = uns_reg;
            acc_addr  = addr_reg;
            acc_wdata = wdata_reg;
        end
    end

    assign acc_idx    = acc_addr[AW+1:2];
    assign enter_resp = (state_next == RESP) && !reset;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap = is_misaligned(acc_size, acc_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    dmem_lane_fmt u_lane_fmt (
        .size        (acc_size),
        .addr_lo     (acc_addr[1:0]),
        .is_unsigned (acc_uns),
        .wdata       (acc_wdata),
        .rword       (mem[acc_idx]),
        .be          (be),
        .wdata_al    (wdata_al),
        .load_data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (enter_resp && acc_we && !trap) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[acc_idx][8*b +: 8] <= wdata_al[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else if (enter_resp) begin
            err_reg   <= trap;
            rdata_reg <= (acc_we || trap) ? 32'd0 : load_data;
        end
    end

    assign bus.resp_rdata = rdata_reg;
    assign bus.resp_err   = err_reg;

endmodule
